// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: registered round-robin / fixed-priority request arbiter with grant hold and release.
// Latency: a request sampled on edge k is granted after edge k; a release on edge k hands over on edge k.
// Backpressure: a blocking grant is held until the owner acknowledges or drops its request.
// Ports: clk, rst_n (async active-low); request/acknowledge [PORTS] in;
//        grant [PORTS], grant_valid, grant_encoded [$clog2(PORTS)] out, all registered.

// priority_encoder: picks one set bit of in_vec (highest index, or lowest when LSB_HIGH_PRIORITY).
// Latency: purely combinational.
// Backpressure: none.
module priority_encoder #(
    parameter int WIDTH             = 4,
    parameter bit LSB_HIGH_PRIORITY = 0
) (
    input  logic [WIDTH-1:0]         in_vec,
    output logic                     out_vld,
    output logic [$clog2(WIDTH)-1:0] out_idx,
    output logic [WIDTH-1:0]         out_onehot
);
    localparam int IDX_W = $clog2(WIDTH);

    // Scan toward the winning end so the last hit is the winner.
    always_comb begin
        out_vld = |in_vec;
        out_idx = '0;
        if (LSB_HIGH_PRIORITY) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_vec[i]) out_idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_vec[i]) out_idx = IDX_W'(i);
            end
        end
        out_onehot = out_vld ? (WIDTH'(1) << out_idx) : '0;
    end
endmodule

module rr_grant_arbiter #(
    parameter int PORTS                = 4,
    parameter bit ARB_TYPE_ROUND_ROBIN = 1,
    parameter bit ARB_BLOCK            = 1,
    parameter bit ARB_BLOCK_ACK        = 1,
    parameter bit LSB_HIGH_PRIORITY    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PORTS-1:0]         request,
    input  logic [PORTS-1:0]         acknowledge,
    output logic [PORTS-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(PORTS)-1:0] grant_encoded
);
    localparam int IDX_W = $clog2(PORTS);

    logic [PORTS-1:0] mask;
    logic [PORTS-1:0] masked_request;

    logic             raw_vld;
    logic [IDX_W-1:0] raw_idx;
    logic [PORTS-1:0] raw_onehot;
    logic             msk_vld;
    logic [IDX_W-1:0] msk_idx;
    logic [PORTS-1:0] msk_onehot;

    logic             release_grant;
    logic [IDX_W-1:0] win_idx;
    logic [PORTS-1:0] win_onehot;

    logic [PORTS-1:0] grant_next;
    logic             grant_valid_next;
    logic [IDX_W-1:0] grant_encoded_next;
    logic [PORTS-1:0] mask_next;

    assign masked_request = request & mask;

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_raw_enc (
        .in_vec     (request),
        .out_vld    (raw_vld),
        .out_idx    (raw_idx),
        .out_onehot (raw_onehot)
    );

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_msk_enc (
        .in_vec     (masked_request),
        .out_vld    (msk_vld),
        .out_idx    (msk_idx),
        .out_onehot (msk_onehot)
    );

    always_comb begin
        // Release of the current owner; IDLE always arbitrates.
        if (!grant_valid) begin
            release_grant = 1'b1;
        end else if (!ARB_BLOCK) begin
            release_grant = 1'b1;
        end else if (ARB_BLOCK_ACK) begin
            release_grant = |(grant & acknowledge);
        end else begin
            release_grant = ~|(grant & request);
        end

        // Masked winner continues the rotation past the last owner; an empty
        // masked vector wraps around to the raw encoder.
        if (ARB_TYPE_ROUND_ROBIN && msk_vld) begin
            win_idx    = msk_idx;
            win_onehot = msk_onehot;
        end else begin
            win_idx    = raw_idx;
            win_onehot = raw_onehot;
        end

        grant_next         = grant;
        grant_valid_next   = grant_valid;
        grant_encoded_next = grant_encoded;
        mask_next          = mask;

        if (release_grant) begin
            if (raw_vld) begin
                grant_next         = win_onehot;
                grant_valid_next   = 1'b1;
                grant_encoded_next = win_idx;
                if (ARB_TYPE_ROUND_ROBIN) begin
                    // Only ports on the lower-priority side of the winner stay eligible
                    // for the masked encoder next time.
                    for (int j = 0; j < PORTS; j++) begin
                        mask_next[j] = LSB_HIGH_PRIORITY ? (j > int'(win_idx))
                                                         : (j < int'(win_idx));
                    end
                end
            end else begin
                grant_next         = '0;
                grant_valid_next   = 1'b0;
                grant_encoded_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_encoded <= '0;
            mask          <= '0;
        end else begin
            grant         <= grant_next;
            grant_valid   <= grant_valid_next;
            grant_encoded <= grant_encoded_next;
            mask          <= mask_next;
        end
    end
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: five arbiter configurations driven by shared request/acknowledge stimulus.
// Latency: expected grants follow one clock after the sampled inputs.
// Backpressure: not applicable.
`timescale 1ns/1ps
module tb_rr_grant_arbiter;
    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] request = 4'b0;
    logic [3:0] acknowledge = 4'b0;

    logic [3:0] g  [N];
    logic       gv [N];
    logic [1:0] ge [N];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // 0: round-robin, ack release     1: fixed priority, ack release
    // 2: round-robin, request release 3: round-robin, non-blocking
    // 4: round-robin, ack release, index 0 highest
    rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(0))
        u_rr_ack (.clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
                  .grant(g[0]), .grant_valid(gv[0]), .grant_encoded(ge[0]));
    rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(0))
        u_fixed (.clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
                 .grant(g[1]), .grant_valid(gv[1]), .grant_encoded(ge[1]));
    rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(0))
        u_rr_req (.clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
                  .grant(g[2]), .grant_valid(gv[2]), .grant_encoded(ge[2]));
    rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(0))
        u_rr_nb (.clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
                 .grant(g[3]), .grant_valid(gv[3]), .grant_encoded(ge[3]));
    rr_grant_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(1))
        u_rr_lsb (.clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
                  .grant(g[4]), .grant_valid(gv[4]), .grant_encoded(ge[4]));

    function automatic bit cfg_rr(int n);   return n != 1; endfunction
    function automatic bit cfg_blk(int n);  return n != 3; endfunction
    function automatic bit cfg_ackm(int n); return n != 2; endfunction
    function automatic bit cfg_lsb(int n);  return n == 4; endfunction

    // Model: owner index, validity, and the last port that won. Round-robin
    // means "search cyclically from the port after the last winner".
    bit m_vld  [N];
    int m_idx  [N];
    int m_last [N];

    function automatic void model_reset(int n);
        m_vld[n]  = 1'b0;
        m_idx[n]  = 0;
        // With no history, the search must start at the top-priority port.
        m_last[n] = cfg_lsb(n) ? 3 : 0;
    endfunction

    function automatic void model_step(int n);
        bit rel;
        int w;
        int c;
        if (!m_vld[n] || !cfg_blk(n)) rel = 1'b1;
        else if (cfg_ackm(n))         rel = acknowledge[m_idx[n]];
        else                          rel = !request[m_idx[n]];
        if (rel) begin
            if (request == 4'b0) begin
                m_vld[n] = 1'b0;
                m_idx[n] = 0;
            end else begin
                w = -1;
                for (int k = 0; k < 4; k++) begin
                    if (!cfg_rr(n)) c = cfg_lsb(n) ? k : 3 - k;
                    else            c = cfg_lsb(n) ? (m_last[n] + 1 + k) % 4
                                                   : (m_last[n] + 3 - k) % 4;
                    if (w < 0 && request[c]) w = c;
                end
                m_vld[n]  = 1'b1;
                m_idx[n]  = w;
                m_last[n] = w;
            end
        end
    endfunction

    initial begin
        for (int n = 0; n < N; n++) model_reset(n);
        forever begin
            @(posedge clk or negedge rst_n);
            for (int n = 0; n < N; n++) begin
                if (!rst_n) model_reset(n);
                else        model_step(n);
            end
        end
    end

    // Every falling edge: all instances against the model.
    initial begin
        logic [3:0] eg;
        logic [1:0] ee;
        forever begin
            @(negedge clk);
            for (int n = 0; n < N; n++) begin
                eg = m_vld[n] ? 4'(1 << m_idx[n]) : 4'b0;
                ee = m_vld[n] ? 2'(m_idx[n]) : 2'b0;
                checks++;
                if (g[n] !== eg || gv[n] !== m_vld[n] || ge[n] !== ee) begin
                    failures++;
                    $display("FAIL model_cmp inst%0d t=%0t: grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                             n, $time, g[n], gv[n], ge[n], eg, m_vld[n], ee);
                end
            end
        end
    end

    task automatic expect_grant(input int n, input logic [3:0] eg, input logic ev,
                                input logic [1:0] ee, input string name);
        checks++;
        if (g[n] !== eg || gv[n] !== ev || ge[n] !== ee) begin
            failures++;
            $display("FAIL %s inst%0d t=%0t: grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                     name, n, $time, g[n], gv[n], ge[n], eg, ev, ee);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        request     = 4'b0;
        acknowledge = 4'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] msb_exp;
        logic [3:0] lsb_exp;

        @(negedge clk);
        for (int n = 0; n < N; n++) expect_grant(n, 4'b0000, 1'b0, 2'd0, "reset_state");
        do_reset();

        // Rotation: acking every port releases every owner each cycle.
        request     = 4'b1111;
        acknowledge = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            msb_exp = 4'b1000 >> (i % 4);
            lsb_exp = 4'b0001 << (i % 4);
            expect_grant(0, msb_exp, 1'b1, 2'(3 - i % 4), "rr_rotation");
            expect_grant(3, msb_exp, 1'b1, 2'(3 - i % 4), "nonblock_rotation");
            expect_grant(4, lsb_exp, 1'b1, 2'(i % 4), "lsb_rotation");
            expect_grant(1, 4'b1000, 1'b1, 2'd3, "fixed_top_wins");
            tick();
        end

        // Fixed priority: port 2 beats port 0 for as long as it requests.
        do_reset();
        request     = 4'b0101;
        acknowledge = 4'b1111;
        repeat (4) begin
            tick();
            expect_grant(1, 4'b0100, 1'b1, 2'd2, "fixed_priority");
        end
        request = 4'b0001;
        tick();
        expect_grant(1, 4'b0001, 1'b1, 2'd0, "fixed_after_drop");

        // Hold: foreign ack and a dropped request do not release an ack-mode grant.
        do_reset();
        request = 4'b0100;
        tick();
        expect_grant(0, 4'b0100, 1'b1, 2'd2, "hold_initial");
        request     = 4'b0001;
        acknowledge = 4'b0001;
        tick();
        expect_grant(0, 4'b0100, 1'b1, 2'd2, "hold_foreign_ack");
        request     = 4'b0011;
        acknowledge = 4'b0100;
        tick();
        expect_grant(0, 4'b0010, 1'b1, 2'd1, "hold_release");
        acknowledge = 4'b0000;

        // Request-release mode.
        do_reset();
        request = 4'b0110;
        tick();
        expect_grant(2, 4'b0100, 1'b1, 2'd2, "reqrel_initial");
        request = 4'b0010;
        tick();
        expect_grant(2, 4'b0010, 1'b1, 2'd1, "reqrel_handover");
        request = 4'b0000;
        tick();
        expect_grant(2, 4'b0000, 1'b0, 2'd0, "reqrel_idle");

        // Reset between edges clears outputs at once and clears the rotation mask.
        do_reset();
        request = 4'b0110;
        tick();
        acknowledge = 4'b0100;
        tick();
        expect_grant(0, 4'b0010, 1'b1, 2'd1, "midrst_before");
        acknowledge = 4'b0000;
        #2 rst_n = 1'b0;
        #1 expect_grant(0, 4'b0000, 1'b0, 2'd0, "midrst_async");
        @(negedge clk);
        request = 4'b0011;
        rst_n   = 1'b1;
        tick();
        expect_grant(0, 4'b0010, 1'b1, 2'd1, "midrst_recover");

        // Random phase: sticky requests, sparse acks, rare mid-cycle resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            request = request ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            acknowledge = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Registered multi-port arbiter with round-robin or fixed priority and grant hold/release control, built on two `priority_encoder` instances: one on the masked request vector, one on the raw request vector. It sits downstream of the request-vector sources (MAC/DMA ports, mux select paths) and drives the select and grant inputs of AXI-Stream muxes and shared-resource front ends. Grants change only on clock edges.

## Interface
- `PORTS`, 4: number of requesters. Must be at least 2.
- `ARB_TYPE_ROUND_ROBIN`, 1: 1 selects round-robin; 0 selects fixed priority.
- `ARB_BLOCK`, 1: 1 holds the grant until release; 0 re-arbitrates every cycle.
- `ARB_BLOCK_ACK`, 1: only meaningful when `ARB_BLOCK` = 1. 1 releases on `acknowledge`; 0 releases when the granted `request` deasserts.
- `LSB_HIGH_PRIORITY`, 0: 0 makes the highest index win; 1 makes index 0 win.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `request`  in  PORTS  per-port request level.
- `acknowledge`  in  PORTS  per-port release pulse.
- `grant`  out  PORTS  one-hot grant, registered.
- `grant_valid`  out  1  any grant active, registered.
- `grant_encoded`  out  $clog2(PORTS)  binary index of `grant`, registered.

## Operation
- **State:** grant register (`grant`, `grant_valid`, `grant_encoded`) plus round-robin mask register (PORTS bits).
- **Logical states:**
  - IDLE: `grant_valid` = 0.
  - GRANTED: `grant_valid` = 1, port `g` holds the grant.
- **Release condition in GRANTED**, evaluated each cycle:
  - `ARB_BLOCK` = 0: always released.
  - `ARB_BLOCK` = 1, `ARB_BLOCK_ACK` = 1: released when `acknowledge[g]` = 1.
  - `ARB_BLOCK` = 1, `ARB_BLOCK_ACK` = 0: released when `request[g]` = 0.
- **Selection**, in IDLE or on a released edge:
  - Masked vector = `request` & mask.
  - If the masked vector is nonzero, take the winner of the masked encoder; otherwise take the winner of the raw encoder.
  - Fixed priority: mask is ignored and the raw encoder is always used.
- **On a selection edge:**
  - If `request` = 0: load grant = 0, `grant_valid` = 0, `grant_encoded` = 0 (go to IDLE).
  - Otherwise: load the one-hot winner, its index, and `grant_valid` = 1.
- **Mask update:** on each edge that loads a winner `i`, round-robin only.
  - `LSB_HIGH_PRIORITY` = 0: mask = bits [i-1:0] set. This is empty when i = 0, which wraps to full priority.
  - `LSB_HIGH_PRIORITY` = 1: mask = bits [PORTS-1:i+1] set. This is empty when i = PORTS-1.
- **Not released in GRANTED:** all registers hold. Changes on other ports' `request` are ignored.
- **`acknowledge`:** bits for non-granted ports are ignored. `acknowledge` in IDLE is ignored.
- **Release and re-request together:** the releasing port may be re-granted on the same edge only if no other port is requesting.
- **Request-release mode:** the granted port dropping its request and re-raising it in the same cycle is invisible; no release occurs.

## Timing
- **Reset:** while `rst_n` = 0, `grant` = 0, `grant_valid` = 0, `grant_encoded` = 0 and mask = 0. This takes effect asynchronously with no clock required. Deassertion is treated as synchronized externally.
- **Grant latency:** a request sampled at edge k in IDLE produces a valid grant after edge k (1 cycle).
- **Hand-over:** release seen at edge k gives the new grant after edge k. There is no idle bubble between back-to-back grants.
- **Output stability:** outputs are purely registered, with no combinational path from inputs to outputs.
- **Consistency:** `grant` always equals 1 << `grant_encoded` when `grant_valid` = 1. It is 0 otherwise.

## Test plan
All scenarios use PORTS=4 and LSB_HIGH_PRIORITY=0 unless stated.
- **Round-robin rotation:** RR with ACK mode. After reset, hold `request`=1111 and pulse `acknowledge[g]` the cycle after each grant -> grant sequence 1000, 0100, 0010, 0001, 1000 (wrap). `grant_encoded` = 3, 2, 1, 0, 3, each one cycle after its ack.
- **Fixed priority:** `ARB_TYPE_ROUND_ROBIN`=0, `request`=0101, ack every grant -> grant stays 0100 (`grant_encoded`=2) indefinitely. Port 0 is granted only after `request[2]` drops and a release occurs.
- **Hold behaviour:** while grant=0100 in ACK mode, pulse `acknowledge[0]` and drop `request[2]` -> grant remains 0100. Then pulse `acknowledge[2]` with `request`=0011 -> next grant is 0010.
- **Request-release mode:** `ARB_BLOCK_ACK`=0, `request`=0110 -> grant 0100. Drop `request[2]` at edge k -> grant 0010 after edge k. Drop all requests -> grant 0 and `grant_valid`=0 one cycle later.
- **Non-blocking mode:** `ARB_BLOCK`=0 with `request`=1111 held -> grant rotates every cycle: 1000, 0100, 0010, 0001, 1000.
- **Reset mid-operation:** assert `rst_n`=0 between edges while grant=0010 -> outputs go to 0 immediately. After release with `request`=0011 -> grant 0010 (mask cleared), one cycle after the first edge.
